// File: rtl/rf_exec_sequencer_if.sv
// Bundle between the execute sequencer, its instruction source and the 4x8 register file:
// the instruction valid/ready handshake plus the register file read and write ports.
interface rf_exec_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr;
  logic [DATA_W-1:0] instr_imm;

  logic [ADDR_W-1:0] rf_out_addr1;
  logic [ADDR_W-1:0] rf_out_addr2;
  logic              rf_read_en;
  logic [DATA_W-1:0] rf_rd_data1;
  logic [DATA_W-1:0] rf_rd_data2;
  logic [ADDR_W-1:0] rf_in_addr;
  logic [DATA_W-1:0] rf_in_data;
  logic              rf_reg_write;

  // The sequencer's view: it accepts instructions and drives the register file.
  modport slave (
    input  instr_valid, instr, instr_imm, rf_rd_data1, rf_rd_data2,
    output instr_ready, rf_out_addr1, rf_out_addr2, rf_read_en,
           rf_in_addr, rf_in_data, rf_reg_write
  );

  // The environment's view: instruction source plus register file.
  modport master (
    output instr_valid, instr, instr_imm, rf_rd_data1, rf_rd_data2,
    input  instr_ready, rf_out_addr1, rf_out_addr2, rf_read_en,
           rf_in_addr, rf_in_data, rf_reg_write
  );
endinterface

// File: rtl/rf_exec_sequencer.sv
// Four-state execute/write-back sequencer in front of the 4x8 register file:
// IDLE accepts, DECODE reads operands, EXEC computes, WB writes back and retires.
module rf_exec_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  rf_exec_sequencer_if.slave  bus,
  output logic                flag_zero,
  output logic                flag_carry,
  output logic                done,
  output logic                illegal
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_MOV = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  logic [1:0]        state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_res_q, carry_res_d;
  logic              flag_zero_q, flag_zero_d;
  logic              flag_carry_q, flag_carry_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              op_writes;
  logic              op_sets_flags;
  logic              op_illegal;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  assign opcode   = instr_q[7:4];
  assign rd_addr  = instr_q[3:2];
  assign rs2_addr = instr_q[1:0];

  assign op_writes     = (opcode >= OP_ADD) && (opcode <= OP_LDI);
  assign op_sets_flags = ((opcode >= OP_ADD) && (opcode <= OP_SHR)) || (opcode == OP_CMP);
  assign op_illegal    = (opcode > OP_CMP);

  // The extra top bit of the widened sum/difference is the carry-out or borrow.
  assign sum_ext  = {1'b0, op1_q} + {1'b0, op2_q};
  assign diff_ext = {1'b0, op1_q} - {1'b0, op2_q};

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_result = sum_ext[DATA_W-1:0];
        alu_carry  = sum_ext[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        alu_result = diff_ext[DATA_W-1:0];
        alu_carry  = diff_ext[DATA_W];
      end
      OP_AND: alu_result = op1_q & op2_q;
      OP_OR:  alu_result = op1_q | op2_q;
      OP_XOR: alu_result = op1_q ^ op2_q;
      OP_NOT: alu_result = ~op1_q;
      OP_SHL: begin
        alu_result = {op1_q[DATA_W-2:0], 1'b0};
        alu_carry  = op1_q[DATA_W-1];
      end
      OP_SHR: begin
        alu_result = {1'b0, op1_q[DATA_W-1:1]};
        alu_carry  = op1_q[0];
      end
      OP_MOV: alu_result = op2_q;
      OP_LDI: alu_result = imm_q;
      default: begin
        alu_result = '0;
        alu_carry  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    imm_d        = imm_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    result_d     = result_q;
    carry_res_d  = carry_res_q;
    flag_zero_d  = flag_zero_q;
    flag_carry_d = flag_carry_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          imm_d   = bus.instr_imm;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op1_d   = bus.rf_rd_data1;
        op2_d   = bus.rf_rd_data2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d    = alu_result;
        carry_res_d = alu_carry;
        state_d     = S_WB;
      end
      default: begin
        if (op_sets_flags) begin
          flag_zero_d  = (result_q == '0);
          flag_carry_d = carry_res_q;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      imm_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      result_q     <= '0;
      carry_res_q  <= 1'b0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      imm_q        <= imm_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      result_q     <= result_d;
      carry_res_q  <= carry_res_d;
      flag_zero_q  <= flag_zero_d;
      flag_carry_q <= flag_carry_d;
    end
  end

  // Reset forces IDLE asynchronously, so a WB write in flight drops at once.
  assign bus.instr_ready  = reset && (state_q == S_IDLE);
  assign bus.rf_read_en   = (state_q == S_DECODE);
  assign bus.rf_out_addr1 = (state_q == S_DECODE) ? rd_addr  : '0;
  assign bus.rf_out_addr2 = (state_q == S_DECODE) ? rs2_addr : '0;
  assign bus.rf_in_addr   = (state_q == S_WB) ? rd_addr  : '0;
  assign bus.rf_in_data   = (state_q == S_WB) ? result_q : '0;
  assign bus.rf_reg_write = (state_q == S_WB) && op_writes;

  assign done       = (state_q == S_WB);
  assign illegal    = (state_q == S_WB) && op_illegal;
  assign flag_zero  = flag_zero_q;
  assign flag_carry = flag_carry_q;

endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Scoreboard bench for rf_exec_sequencer: a behavioural register/flag model predicts each
// retirement, and a monitor compares it whenever the sequencer signals done.
module tb_rf_exec_sequencer;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flag_zero, flag_carry, done, illegal;

  rf_exec_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_exec_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Register file the sequencer talks to: combinational read, write on the rising edge.
  logic [7:0] rf [4] = '{default: 8'h00};
  assign bus.rf_rd_data1 = rf[bus.rf_out_addr1];
  assign bus.rf_rd_data2 = rf[bus.rf_out_addr2];
  always @(posedge clk) if (bus.rf_reg_write) rf[bus.rf_in_addr] <= bus.rf_in_data;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int rs1;
    int rs2;
    bit wr;
    int wa;
    int wd;
    bit ill;
    bit z;
    bit c;
    bit abort;
    int acc;
  } exp_t;

  exp_t q[$];
  int   mreg [4];
  bit   mz, mc;
  int   checks = 0;
  int   passes = 0;
  int   rd_seen = 0;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic report_fail(input string name);
    checks++;
    $display("[TB] FAIL %s: got timeout/unexpected event required orderly completion", name);
  endtask

  // Architectural meaning of one instruction, computed from the current model state.
  function automatic exp_t model(input int op, input int rd, input int rs2, input int imm);
    exp_t e;
    int   a, b, r;
    bit   c, setf, wr;
    e = '{default: 0};
    a = mreg[rd];
    b = mreg[rs2];
    r = 0;
    c = 1'b0;
    setf = 1'b0;
    wr = 1'b0;
    case (op)
      1:  begin r = a + b; c = (r > 255); r = r % 256; wr = 1; setf = 1; end
      2:  begin r = (a - b + 256) % 256; c = (a < b); wr = 1; setf = 1; end
      3:  begin r = a & b; wr = 1; setf = 1; end
      4:  begin r = a | b; wr = 1; setf = 1; end
      5:  begin r = a ^ b; wr = 1; setf = 1; end
      6:  begin r = 255 - a; wr = 1; setf = 1; end
      7:  begin r = (a * 2) % 256; c = (a >= 128); wr = 1; setf = 1; end
      8:  begin r = a / 2; c = (a % 2 == 1); wr = 1; setf = 1; end
      9:  begin r = b; wr = 1; end
      10: begin r = imm; wr = 1; end
      11: begin r = (a - b + 256) % 256; c = (a < b); setf = 1; end
      default: ;
    endcase
    e.rs1 = rd;
    e.rs2 = rs2;
    e.wa  = rd;
    e.wr  = wr;
    e.wd  = wr ? r : 0;
    e.ill = (op >= 12);
    e.z   = setf ? (r == 0) : mz;
    e.c   = setf ? c : mc;
    return e;
  endfunction

  // Presents one instruction at a negedge, waits for acceptance and the return of ready.
  task automatic apply_stimulus(input int op, input int rd, input int rs2, input int imm,
                                input bit hold);
    exp_t e;
    int   w;
    bus.instr       = 8'((op << 4) | (rd << 2) | rs2);
    bus.instr_imm   = 8'(imm);
    bus.instr_valid = 1'b1;
    w = 0;
    while (!bus.instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.instr_ready) begin
      report_fail("accept_timeout");
      bus.instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(op, rd, rs2, imm);
    e.acc = ecount;
    q.push_back(e);
    if (e.wr) mreg[rd] = e.wd;
    mz = e.z;
    mc = e.c;
    if (!hold) bus.instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("ready_while_busy", int'(bus.instr_ready), 0);
    end
    @(negedge clk);
    check_output("ready_after_4", int'(bus.instr_ready), 1);
    bus.instr_valid = 1'b0;
  endtask

  // Issues ADD r0,r1 and pulls reset low in the middle of its write-back cycle.
  task automatic abort_add_in_wb();
    exp_t e;
    bus.instr       = 8'h11;
    bus.instr_imm   = 8'h00;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    e = model(1, 0, 1, 0);
    e.acc   = ecount;
    e.abort = 1'b1;
    q.push_back(e);
    bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("abort_reg_write", int'(bus.rf_reg_write), 0);
    check_output("abort_ready", int'(bus.instr_ready), 0);
    check_output("abort_flag_zero", int'(flag_zero), 0);
    check_output("abort_flag_carry", int'(flag_carry), 0);
    check_output("abort_done", int'(done), 0);
    mz = 1'b0;
    mc = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_output("ready_in_reset", int'(bus.instr_ready), 0);
    end
    #2;
    reset = 1'b1;
    #1;
    check_output("ready_after_release", int'(bus.instr_ready), 1);
    @(negedge clk);
    check_output("r0_after_abort", int'(rf[0]), mreg[0]);
  endtask

  // Monitor: compares each retirement against the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rf_read_en) begin
        rd_seen++;
        if (q.size() == 0) report_fail("read_without_instr");
        else begin
          check_output("rd_addr1", int'(bus.rf_out_addr1), q[0].rs1);
          check_output("rd_addr2", int'(bus.rf_out_addr2), q[0].rs2);
        end
      end else begin
        check_output("rd_addr_idle", int'({bus.rf_out_addr1, bus.rf_out_addr2}), 0);
      end
      if (done) begin
        if (q.size() == 0) report_fail("unexpected_done");
        else begin
          e = q.pop_front();
          check_output("done_latency", ecount, e.acc + 2);
          check_output("read_en_pulses", rd_seen, 1);
          check_output("illegal", int'(illegal), int'(e.ill));
          check_output("reg_write", int'(bus.rf_reg_write), int'(e.wr));
          if (e.wr) begin
            check_output("wr_addr", int'(bus.rf_in_addr), e.wa);
            check_output("wr_data", int'(bus.rf_in_data), e.wd);
          end
          if (!e.abort) begin
            @(posedge clk);
            #1;
            check_output("flag_zero", int'(flag_zero), int'(e.z));
            check_output("flag_carry", int'(flag_carry), int'(e.c));
          end
        end
        rd_seen = 0;
      end else begin
        check_output("wb_outputs_idle",
                     int'({bus.rf_reg_write, illegal, bus.rf_in_addr, bus.rf_in_data}), 0);
      end
    end
  end

  initial begin
    int w;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.instr_imm   = 8'h00;
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    mz = 1'b0;
    mc = 1'b0;

    repeat (2) @(negedge clk);
    check_output("reset_ready", int'(bus.instr_ready), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_flags", int'({flag_zero, flag_carry}), 0);
    check_output("reset_reg_write", int'(bus.rf_reg_write), 0);
    #2;
    reset = 1'b1;
    #1;
    check_output("ready_first_cycle", int'(bus.instr_ready), 1);
    @(negedge clk);

    apply_stimulus(10, 0, 0, 8'h05, 0);
    apply_stimulus(10, 1, 0, 8'hFB, 0);
    apply_stimulus(1, 0, 1, 0, 0);
    apply_stimulus(10, 2, 0, 8'h10, 0);
    apply_stimulus(10, 3, 0, 8'h20, 0);
    apply_stimulus(2, 2, 3, 0, 0);
    apply_stimulus(11, 3, 3, 0, 0);
    apply_stimulus(10, 1, 0, 8'h81, 0);
    apply_stimulus(7, 1, 0, 0, 0);
    apply_stimulus(8, 1, 0, 0, 0);
    apply_stimulus(6, 1, 0, 0, 0);
    apply_stimulus(14, 2, 1, 0, 1);
    apply_stimulus(10, 2, 0, 8'h33, 0);
    apply_stimulus(9, 3, 2, 0, 0);
    apply_stimulus(1, 1, 1, 0, 0);
    abort_add_in_wb();

    repeat (60) begin
      apply_stimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                     bit'($urandom_range(0, 1)));
    end

    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) report_fail("scoreboard_drain");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check_output("final_reg", int'(rf[i]), mreg[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rf_exec_sequencer.md
Name: rf_exec_sequencer

Overview:
- Multi-cycle execute/write-back sequencer placed directly in front of the 4x8 general-purpose register file.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives the register file's two read addresses and its read enable, latches the returned operands, and computes an ALU result.
- Writes the result back through the file's write port and updates zero/carry flags.

Parameters:
DATA_W, 8, operand/result width; must match register file data width
ADDR_W, 2, register address width (4 registers)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
instr_valid  input  1  instr/instr_imm presented
instr_ready  output  1  sequencer can accept (IDLE only)
instr  input  8  [7:4] opcode, [3:2] rd/rs1, [1:0] rs2
instr_imm  input  DATA_W  immediate for LDI
rf_out_addr1  output  ADDR_W  to register file out_address1 (rs1)
rf_out_addr2  output  ADDR_W  to register file out_address2 (rs2)
rf_read_en  output  1  to register file read_en
rf_rd_data1  input  DATA_W  from register file out_data1
rf_rd_data2  input  DATA_W  from register file out_data2
rf_in_addr  output  ADDR_W  to register file in_address
rf_in_data  output  DATA_W  to register file in_data
rf_reg_write  output  1  to register file reg_write
flag_zero  output  1  last result == 0
flag_carry  output  1  carry/borrow/shift-out of last flag-setting op
done  output  1  one-cycle pulse, instruction retired
illegal  output  1  one-cycle pulse with done, opcode C-F

Behaviour:
- FSM has four states: IDLE -> DECODE -> EXEC -> WB -> IDLE. Every instruction takes the full path; there are no shortcuts.
- IDLE:
  - instr_ready=1.
  - On valid&ready at edge E0, latch instr and instr_imm, then go to DECODE.
  - No other state accepts an instruction.
- DECODE:
  - rf_read_en=1, rf_out_addr1=instr[3:2], rf_out_addr2=instr[1:0].
  - Latch rf_rd_data1/2 into operand registers at edge E1.
  - The register file read is combinational.
- EXEC:
  - Compute result and next-carry from the latched operands.
  - Register both at edge E2.
- WB:
  - rf_in_addr=instr[3:2], rf_in_data=result.
  - rf_reg_write=1 for writing opcodes only.
  - done=1; illegal=1 if opcode C-F.
  - Flags update at edge E3 for flag-setting opcodes.
  - Write commits at E3.
- Latency: accept edge E0 to write-commit edge E3. Throughput is 1 instruction per 4 cycles.
- Opcodes (writes rd unless noted):
  - 0 NOP: no write, flags held.
  - 1 ADD: rs1+rs2; carry = bit 8 of the 9-bit sum.
  - 2 SUB: rs1-rs2 mod 256; carry = borrow (rs1<rs2).
  - 3 AND, 4 OR, 5 XOR: carry cleared.
  - 6 NOT: ~rs1; carry cleared.
  - 7 SHL: rs1<<1, 0 in; carry = old bit 7.
  - 8 SHR: rs1>>1 logical; carry = old bit 0.
  - 9 MOV: rd=rs2; flags held.
  - A LDI: rd=instr_imm; flags held.
  - B CMP: SUB flags only, no write.
  - C-F: treated as NOP, illegal pulses.
- flag_zero = (result==0), updated only by ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, CMP.
- Outside WB, rf_reg_write=0, rf_in_addr=0, rf_in_data=0.
- Outside DECODE, rf_read_en=0 and read addresses=0.
- Read-after-write: the write commits before IDLE, so the next instruction's DECODE always sees the updated value. The sequencer needs no forwarding.
- rd==rs1==rs2 is legal, e.g. ADD r1,r1 doubles r1.
- instr_valid held high while not ready: ignored and not latched. The upstream must hold instr until accepted.
- Reset asserted (reset=0), including mid-operation:
  - Immediately go to IDLE.
  - instr_ready=0 while in reset.
  - All rf_* outputs=0, so a pending WB write is aborted.
  - done=illegal=0; flags=0; operand/result registers=0.
  - instr_ready=1 in the first cycle after reset is released.

Test Plan:
- Reset, then LDI r0 imm=0x05, LDI r1 imm=0xFB, ADD r0,r1 -> r0=0x00, flag_zero=1, flag_carry=1; done once per instr, each 3 cycles after accept.
- r2=0x10, r3=0x20: SUB r2,r3 -> r2=0xF0, carry=1, zero=0; then CMP r3,r3 -> no reg_write, zero=1, carry=0, r3 still 0x20.
- r1=0x81: SHL r1 -> 0x02, carry=1; SHR r1 -> 0x01, carry=0; NOT r1 -> 0xFE, carry=0.
- Opcode 0xE issued -> illegal and done pulse together, rf_reg_write stays 0, flags unchanged; instr_valid held high in DECODE/EXEC/WB -> not re-accepted; instr_ready back to 1 exactly 4 cycles after accept.
- Back-to-back LDI r2 0x33 then MOV r3,r2 -> r3=0x33 (RAW through file); rf_read_en high only in the DECODE cycle.
- Assert reset during WB of ADD to r0 -> rf_reg_write drops asynchronously, r0 unchanged, flags=0, instr_ready=0 until release, then 1.
